// File: rtl/interp_filt_pkg.sv
// Shared types and defaults for the interpolation filter.
// Used by the tap generator and the downstream adder.
package interp_filt_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_COEF_WIDTH = 6;
  localparam int DEF_COEF_FRAC  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/polyphase_tap_gen_sat_shift.sv
// Arithmetic right shift of a signed product, then clamp
// to the signed output range.
module sat_shift #(
  parameter int IN_W  = 12,
  parameter int SHIFT = 4,
  parameter int OUT_W = 6
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAXV =
    IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MINV =
    IN_W'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W-1:0] s;

  assign s = din >>> SHIFT;

  // Clamp the scaled product into the output width.
  always_comb begin
    dout = s[OUT_W-1:0];
    if (s > MAXV) begin
      dout = MAXV[OUT_W-1:0];
    end else if (s < MINV) begin
      dout = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/polyphase_tap_gen.sv
// Polyphase tap generator: delay line plus one beat per
// phase of coefficient-weighted, saturated tap products.
module polyphase_tap_gen
  import interp_filt_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_TAPS   = 2,
  parameter int INTERP     = 2,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int COEF_FRAC  = DEF_COEF_FRAC,
  localparam int PW        = $clog2(INTERP)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic [INTERP*NUM_TAPS*COEF_WIDTH-1:0]  coef,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PW-1:0]                          out_phase,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]         out_taps
);

  localparam logic [PW-1:0] LAST = PW'(INTERP - 1);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  state_e state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];

  logic xfer;
  logic last;
  logic accept;

  assign out_valid = (state_q == RUN);
  assign out_phase = phase_q;
  assign xfer      = out_valid && out_ready;
  assign last      = (phase_q == LAST);
  assign in_ready  = (state_q == IDLE) || (xfer && last);
  assign accept    = in_valid && in_ready;

  // Next state: shift on accept, advance phase on transfer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    for (int k = 0; k < NUM_TAPS; k++) begin
      x_d[k] = x_q[k];
    end
    if (accept) begin
      x_d[0] = $signed(in_data);
      for (int k = 1; k < NUM_TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      phase_d = '0;
      state_d = RUN;
    end else if (xfer) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // State, phase and delay-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= x_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic signed [COEF_WIDTH-1:0] c;
    logic signed [PROD_W-1:0]     prod;

    assign c = $signed(coef[(int'(phase_q) * NUM_TAPS + k)
                            * COEF_WIDTH +: COEF_WIDTH]);
    assign prod = x_q[k] * c;

    sat_shift #(
      .IN_W  (PROD_W),
      .SHIFT (COEF_FRAC),
      .OUT_W (DATA_WIDTH)
    ) u_sat (
      .din  (prod),
      .dout (out_taps[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_polyphase_tap_gen.sv
// Randomised bench for polyphase_tap_gen with a beat-queue
// reference model and directed literal checks.
module tb_polyphase_tap_gen;

  localparam int DW = 6;
  localparam int NT = 2;
  localparam int IP = 2;
  localparam int CW = 6;
  localparam int CF = 4;
  localparam int PW = $clog2(IP);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [IP*NT*CW-1:0] coef = '0;
  logic in_ready;
  logic out_valid;
  logic [PW-1:0] out_phase;
  logic [NT*DW-1:0] out_taps;

  polyphase_tap_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_phase (out_phase),
    .out_taps  (out_taps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int t0;
    int t1;
  } beat_t;

  int checks = 0;
  int errors = 0;
  beat_t expq[$];
  beat_t obs[$];
  int hist [NT];
  int cf [IP*NT];

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  function automatic int tap(input int x, input int c);
    int p;
    p = x * c;
    p = p >>> CF;
    if (p > 31) p = 31;
    if (p < -32) p = -32;
    return p;
  endfunction

  function automatic int dut_tap(input int k);
    logic signed [DW-1:0] v;
    v = out_taps[k*DW +: DW];
    return int'(v);
  endfunction

  task automatic set_coef(input int a0, input int a1,
                          input int b0, input int b1);
    cf[0] = a0;
    cf[1] = a1;
    cf[2] = b0;
    cf[3] = b1;
    for (int i = 0; i < IP*NT; i++) begin
      coef[i*CW +: CW] = CW'(cf[i]);
    end
  endtask

  // Reference model: each accepted sample queues IP beats.
  always @(negedge clk) begin
    logic ir_exp;
    logic xfer;
    logic acc;
    beat_t b;
    if (!rst_n) begin
      expq.delete();
      for (int k = 0; k < NT; k++) hist[k] = 0;
    end else begin
      ir_exp = (expq.size() == 0) ||
               (expq.size() == 1 && out_ready);
      check("in_ready", int'(in_ready), int'(ir_exp));
      check("out_valid", int'(out_valid),
            int'(expq.size() != 0));
      if (expq.size() != 0) begin
        check("out_phase", int'(out_phase), expq[0].ph);
        check("tap0", dut_tap(0), expq[0].t0);
        check("tap1", dut_tap(1), expq[0].t1);
      end
      xfer = (expq.size() != 0) && out_ready;
      acc = in_valid && ir_exp;
      if (xfer) begin
        b.ph = int'(out_phase);
        b.t0 = dut_tap(0);
        b.t1 = dut_tap(1);
        obs.push_back(b);
        void'(expq.pop_front());
      end
      if (acc) begin
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(in_data));
        for (int p = 0; p < IP; p++) begin
          b.ph = p;
          b.t0 = tap(hist[0], cf[p*NT]);
          b.t1 = tap(hist[1], cf[p*NT+1]);
          expq.push_back(b);
        end
      end
    end
  end

  task automatic send(input int d, output int cyc);
    logic a;
    in_valid = 1'b1;
    in_data = DW'(d);
    cyc = 0;
    a = 1'b0;
    while (!a && cyc < 100) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) check("idle_timeout", 0, 1);
  endtask

  task automatic chk_obs(input string nm, input int i,
                         input int ph, input int t0,
                         input int t1);
    if (i >= obs.size()) begin
      check({nm, "_missing"}, obs.size(), i + 1);
    end else begin
      check({nm, "_ph"}, obs[i].ph, ph);
      check({nm, "_t0"}, obs[i].t0, t0);
      check({nm, "_t1"}, obs[i].t1, t1);
    end
  endtask

  logic done;
  int base;
  int cyc;

  initial begin
    done = 1'b0;
    set_coef(16, 0, 8, 8);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_phase", int'(out_phase), 0);
    check("rst_taps", int'(out_taps), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two samples at full rate.
    out_ready = 1'b1;
    base = obs.size();
    send(10, cyc);
    send(20, cyc);
    in_valid = 1'b0;
    wait_idle();
    chk_obs("s10p0", base, 0, 10, 0);
    chk_obs("s10p1", base + 1, 1, 5, 0);
    chk_obs("s20p0", base + 2, 0, 20, 0);
    chk_obs("s20p1", base + 3, 1, 10, 5);

    // Backpressure at phase 1 of sample 20.
    send(10, cyc);
    send(20, cyc);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    base = obs.size();
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_phase", int'(out_phase), 1);
      check("bp_t0", dut_tap(0), 10);
      check("bp_t1", dut_tap(1), 5);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("bp_count", obs.size() - base, 1);
    chk_obs("bp_beat", base, 1, 10, 5);

    // Reset in the middle of a run.
    send(5, cyc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_phase", int'(out_phase), 0);
    check("mid_rst_taps", int'(out_taps), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = obs.size();
    send(16, cyc);
    in_valid = 1'b0;
    wait_idle();
    chk_obs("after_rst_p1", base + 1, 1, 8, 0);

    // Saturation and floor rounding.
    set_coef(31, 31, 31, 31);
    base = obs.size();
    send(31, cyc);
    send(-32, cyc);
    in_valid = 1'b0;
    wait_idle();
    check("sat_pos", obs[base].t0, 31);
    check("sat_neg", obs[base + 2].t0, -32);
    set_coef(8, 8, 8, 8);
    base = obs.size();
    send(-1, cyc);
    in_valid = 1'b0;
    wait_idle();
    check("floor_neg1", obs[base].t0, -1);

    // Continuous stream: one accept every IP cycles.
    set_coef(16, 0, 8, 8);
    send(1, cyc);
    for (int i = 2; i <= 20; i++) begin
      send(i, cyc);
      check("stream_gap", cyc, IP);
    end
    in_valid = 1'b0;
    wait_idle();

    // Random backpressure and random samples.
    set_coef(int'($urandom_range(0, 63)) - 32,
             int'($urandom_range(0, 63)) - 32,
             int'($urandom_range(0, 63)) - 32,
             int'($urandom_range(0, 63)) - 32);
    base = obs.size();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(int'($urandom_range(0, 63)), cyc);
          in_valid = 1'b0;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rand_beats", obs.size() - base, 100 * IP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polyphase_tap_gen.md
Name: polyphase_tap_gen

Overview:
Upstream stage of the saturating tap adder in the interpolation filter. Accepts input samples over a valid/ready handshake and holds them in a NUM_TAPS-deep delay line. For each accepted sample it emits INTERP output beats, one per polyphase phase. Each beat carries NUM_TAPS coefficient-weighted, scaled and saturated tap products, which the downstream adder sums.

Parameters:
DATA_WIDTH, 6, signed sample width and per-tap output width
NUM_TAPS, 2, taps per phase (delay-line depth)
INTERP, 2, interpolation factor (number of phases), >=2
COEF_WIDTH, 6, signed coefficient width
COEF_FRAC, 4, coefficient fractional bits (1.0 = 2^COEF_FRAC)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  DATA_WIDTH signed  input sample
coef  in  COEF_WIDTH signed x INTERP*NUM_TAPS  coefficient bank; index p*NUM_TAPS+k = phase p, tap k; quasi-static, changed only while idle
out_valid  out  1  out_taps/out_phase valid
out_ready  in  1  downstream accepts beat
out_phase  out  $clog2(INTERP)  phase index of current beat
out_taps  out  DATA_WIDTH signed x NUM_TAPS  per-tap products, feed to adder inputs

Behaviour:
- Reset (async assert, sync release): delay line x[0..NUM_TAPS-1]=0, phase=0, state IDLE; out_valid=0, out_phase=0, in_ready=1. out_taps = 0, because all taps are 0.
- States: IDLE (no pending beats), RUN (beat pending). out_valid = (state==RUN), registered.
- in_ready = IDLE || (out_valid && out_ready && phase==INTERP-1). This is combinational from registered state and out_ready.
- Accept (in_valid && in_ready) at an edge:
  - Delay line shifts: x[0]<=in_data, x[k]<=x[k-1].
  - phase<=0, state<=RUN.
  - Latency: out_valid is high the cycle after the accept edge.
- Beat transfer (out_valid && out_ready):
  - If phase<INTERP-1: phase<=phase+1.
  - If phase==INTERP-1 with no simultaneous accept: state<=IDLE.
  - If phase==INTERP-1 with a simultaneous accept: the shift takes place, phase<=0, state stays RUN. This gives a bubble-free stream.
- Backpressure: while out_valid && !out_ready, out_phase, out_taps and the delay line hold, and in_ready=0.
- Tap arithmetic (combinational from registered x and phase):
  - prod = x[k] * coef[phase*NUM_TAPS+k], full DATA_WIDTH+COEF_WIDTH signed.
  - s = prod >>> COEF_FRAC (arithmetic shift, floor toward -inf).
  - out_taps[k] = clamp(s, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1).
- Throughput: one beat per cycle; one input per INTERP cycles at full rate.
- in_valid while !in_ready: the sample is not consumed, and the source holds it.
- Reset mid-operation: pending beats are discarded, the delay line is cleared, and outputs return to reset values immediately.
- out_valid never drops without a transfer; beat contents never change while stalled.

Decomposition:
- Shared package interp_filt_pkg:
  - default DATA_WIDTH/COEF_WIDTH/COEF_FRAC constants
  - state enum {IDLE, RUN}
- One sub-module, sat_shift: signed product in, arithmetic shift by COEF_FRAC, clamp to DATA_WIDTH. Instantiated NUM_TAPS times.

Test Plan:
Defaults throughout. Coefs phase0={16,0}, phase1={8,8} unless stated.
1. Reset -> out_valid=0, in_ready=1, out_phase=0, out_taps={0,0}. Assert rst_n=0 mid-RUN -> same values immediately, and the next input sees a zeroed delay line.
2. Feed 10 then 20 with out_ready=1 -> four beats:
   - ph0 {10,0}, ph1 {5,0}
   - ph0 {20,0}, ph1 {10,5}
   - in_ready low the cycle after each accept, high again on ph1 transfer.
3. Saturation/rounding, coef all 31:
   - in 31 -> 961>>>4=60 -> taps 31
   - in -32 -> -62 -> -32
   - coef 8, in -1 -> -8>>>4 -> -1 (floor)
4. Backpressure: out_ready=0 for 3 cycles at ph1 of sample 20 -> {10,5}, out_phase=1 held; in_ready=0 throughout; release -> beat transfers once.
5. in_valid held high (samples 1,2,3,...), out_ready=1 -> out_valid continuously high, one accept every 2 cycles, phases alternate 0,1 with no bubble.
6. out_ready toggling randomly over 100 samples -> beat sequence matches golden model; no dropped or duplicated beat.
